// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: TX FIFO read port, frame configuration and serial line of the UART TX engine.
interface uart_tx_serializer_if #(
   parameter int WORD_SIZE = 8
);
   logic                 txEn_in;
   logic                 parityEn_in;
   logic                 parityOdd_in;
   logic                 stopBits2_in;
   logic                 fifoEmpty_in;
   logic [WORD_SIZE-1:0] fifoData_in;
   logic                 fifoReadEn_out;
   logic                 tx_out;
   logic                 busy_out;
   logic                 frameDone_out;
   modport master (
      output txEn_in, parityEn_in, parityOdd_in, stopBits2_in, fifoEmpty_in, fifoData_in,
      input  fifoReadEn_out, tx_out, busy_out, frameDone_out
   );
   modport slave (
      input  txEn_in, parityEn_in, parityOdd_in, stopBits2_in, fifoEmpty_in, fifoData_in,
      output fifoReadEn_out, tx_out, busy_out, frameDone_out
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops words from the TX FIFO and sends start, LSB-first data, optional parity and 1/2 stop bits.
module uart_tx_serializer #(
   parameter int WORD_SIZE    = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input logic                clk_in,
   input logic                rstN,
   uart_tx_serializer_if.slave txif
);
   localparam int BIT_W = $clog2(WORD_SIZE + 1);
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic                 par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
   logic                 tick, ready, last_data, last_stop, timed;
   assign tick      = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
   assign ready     = txif.txEn_in && !txif.fifoEmpty_in;
   assign last_data = bit_q == BIT_W'(WORD_SIZE - 1);
   assign last_stop = tick && (!stop2_q || bit_q != '0);
   assign timed     = state_q inside {START, DATA, PARITY, STOP};
   always_ff @(posedge clk_in or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         stop2_q  <= stop2_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = (timed && !tick) ? cnt_q + CNT_W'(1) : '0;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      stop2_d  = stop2_q;
      unique case (state_q)
         IDLE:   state_d = ready ? FETCH : IDLE;
         FETCH:  state_d = LOAD;
         LOAD: begin
            shift_d  = txif.fifoData_in;
            par_en_d = txif.parityEn_in;
            par_d    = ^txif.fifoData_in ^ txif.parityOdd_in;
            stop2_d  = txif.stopBits2_in;
            bit_d    = '0;
            state_d  = START;
         end
         START:  state_d = tick ? DATA : START;
         DATA: begin
            shift_d = tick ? shift_q >> 1 : shift_q;
            bit_d   = !tick ? bit_q : last_data ? '0 : bit_q + BIT_W'(1);
            state_d = !tick ? DATA : !last_data ? DATA : par_en_q ? PARITY : STOP;
         end
         PARITY: state_d = tick ? STOP : PARITY;
         STOP: begin
            // bit_q doubles as the stop-bit index so the second stop bit reuses the baud counter
            bit_d   = tick ? bit_q + BIT_W'(1) : bit_q;
            state_d = !last_stop ? STOP : ready ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign txif.fifoReadEn_out = state_q == FETCH;
   assign txif.busy_out       = state_q != IDLE;
   assign txif.frameDone_out  = state_q == STOP && last_stop;
   assign txif.tx_out         = state_q == START  ? 1'b0 :
                                state_q == DATA   ? shift_q[0] :
                                state_q == PARITY ? par_q : 1'b1;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames against a small FIFO model, CLKS_PER_BIT=4.
module tb_uart_tx_serializer;
   localparam int CPB = 4;
   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0, errors = 0, pops = 0, ncyc = 0;
   logic       busy_all;
   logic [7:0] mem [16];
   logic [3:0] wr_ptr = '0, rd_ptr = '0;
   uart_tx_serializer_if #(.WORD_SIZE(8)) bus ();
   uart_tx_serializer #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB)) dut (
      .clk_in(clk),
      .rstN  (rst_n),
      .txif  (bus.slave)
   );
   always #5 clk = ~clk;
   assign bus.fifoEmpty_in = wr_ptr == rd_ptr;
   always @(posedge clk) begin
      if (bus.fifoReadEn_out) begin
         bus.fifoData_in <= mem[rd_ptr];
         rd_ptr          <= rd_ptr + 4'd1;
         pops            <= pops + 1;
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 4'd1;
   endtask
   task automatic sample_bit(output logic [3:0] tx, output logic [3:0] dn);
      for (int k = 0; k < CPB; k++) begin
         @(negedge clk);
         tx[k] = bus.tx_out;
         dn[k] = bus.frameDone_out;
         busy_all &= bus.busy_out;
         ncyc++;
      end
   endtask
   task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic po,
                            input logic s2, input logic pb, input int len, input logic scramble,
                            input logic drop_en, output int gap);
      logic [3:0] tx, dn;
      int         nstop;
      gap = 0;
      while (bus.fifoReadEn_out !== 1'b1 && gap < 500) begin
         @(negedge clk);
         gap++;
      end
      check({tag, " pop"}, 32'(bus.fifoReadEn_out), 32'd1);
      if (bus.fifoReadEn_out !== 1'b1) return;
      bus.parityEn_in  = pe;
      bus.parityOdd_in = po;
      bus.stopBits2_in = s2;
      busy_all = bus.busy_out;
      ncyc = 1;
      check({tag, " fetch tx"}, 32'(bus.tx_out), 32'd1);
      @(negedge clk);
      ncyc++;
      busy_all &= bus.busy_out;
      check({tag, " load tx"}, 32'(bus.tx_out), 32'd1);
      sample_bit(tx, dn);
      check({tag, " start"}, 32'(tx), 32'h0);
      if (scramble) begin
         bus.parityEn_in  = ~pe;
         bus.parityOdd_in = ~po;
         bus.stopBits2_in = ~s2;
      end
      if (drop_en) bus.txEn_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sample_bit(tx, dn);
         check($sformatf("%s d%0d", tag, i), 32'(tx), 32'({4{d[i]}}));
      end
      if (pe) begin
         sample_bit(tx, dn);
         check({tag, " parity"}, 32'(tx), 32'({4{pb}}));
      end
      nstop = s2 ? 2 : 1;
      for (int j = 0; j < nstop; j++) begin
         sample_bit(tx, dn);
         check($sformatf("%s stop%0d", tag, j), 32'(tx), 32'hF);
         check($sformatf("%s done%0d", tag, j), 32'(dn), (j == nstop - 1) ? 32'h8 : 32'h0);
      end
      check({tag, " len"}, 32'(ncyc), 32'(len));
      check({tag, " busy"}, 32'(busy_all), 32'd1);
   endtask
   initial begin
      int   gap, p0;
      logic all_ok;
      rst_n = 1'b0;
      bus.txEn_in = 1'b0;
      bus.parityEn_in = 1'b0;
      bus.parityOdd_in = 1'b0;
      bus.stopBits2_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst tx", 32'(bus.tx_out), 32'd1);
      check("rst busy", 32'(bus.busy_out), 32'd0);
      check("rst rden", 32'(bus.fifoReadEn_out), 32'd0);
      check("rst done", 32'(bus.frameDone_out), 32'd0);
      bus.txEn_in = 1'b1;
      rst_n = 1'b1;
      all_ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         all_ok &= bus.tx_out === 1'b1 && bus.busy_out === 1'b0 && bus.fifoReadEn_out === 1'b0;
      end
      check("idle empty", 32'(all_ok), 32'd1);
      check("idle pops", 32'(pops), 32'd0);
      push(8'hA5);
      run_frame("8n1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b0, gap);
      @(negedge clk);
      check("8n1 pops", 32'(pops), 32'd1);
      check("8n1 idle busy", 32'(bus.busy_out), 32'd0);
      check("8n1 idle tx", 32'(bus.tx_out), 32'd1);
      push(8'h03);
      run_frame("even", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 46, 1'b0, 1'b0, gap);
      @(negedge clk);
      push(8'h03);
      run_frame("odd2", 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 50, 1'b1, 1'b0, gap);
      @(negedge clk);
      p0 = pops;
      push(8'h55);
      push(8'h0F);
      run_frame("b2b1", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b0, gap);
      run_frame("b2b2", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b0, gap);
      check("b2b gap", 32'(gap), 32'd1);
      @(negedge clk);
      check("b2b pops", 32'(pops - p0), 32'd2);
      p0 = pops;
      push(8'h3C);
      push(8'hC3);
      run_frame("gate", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b1, gap);
      repeat (20) @(negedge clk);
      check("gate pops", 32'(pops - p0), 32'd1);
      check("gate busy", 32'(bus.busy_out), 32'd0);
      check("gate tx", 32'(bus.tx_out), 32'd1);
      bus.txEn_in = 1'b1;
      run_frame("resume", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b0, gap);
      @(negedge clk);
      check("resume pops", 32'(pops - p0), 32'd2);
      p0 = pops;
      push(8'h96);
      push(8'h69);
      gap = 0;
      while (bus.fifoReadEn_out !== 1'b1 && gap < 500) begin
         @(negedge clk);
         gap++;
      end
      check("arst pop", 32'(bus.fifoReadEn_out), 32'd1);
      repeat (20) @(negedge clk);
      check("arst pre tx", 32'(bus.tx_out), 32'd0);
      check("arst pre busy", 32'(bus.busy_out), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst tx", 32'(bus.tx_out), 32'd1);
      check("arst busy", 32'(bus.busy_out), 32'd0);
      check("arst rden", 32'(bus.fifoReadEn_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("arst pops", 32'(pops - p0), 32'd1);
      run_frame("arst next", 8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 42, 1'b0, 1'b0, gap);
      @(negedge clk);
      check("arst next pops", 32'(pops - p0), 32'd2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
